cla_pipe_addsub: RTL

//   Parametrised, pipelined carry-look-ahead adder/subtractor. Successor to the fixed
//   16-bit combinational cla16: width and pipeline depth are parameters, plus an add/sub

---
 rtl/cla_pipe_addsub.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub -- parametrised, pipelined carry-look-ahead adder/subtractor.
//
// The operand is cut into STAGES slices of S = WIDTH/STAGES bits. Stage k adds
// slice k with a chain of 4-bit CLA groups. Its carry-in is the registered carry
// of stage k-1. The upper operand bits and the finished lower sum bits travel
// alongside in the stage registers. The longest combinational path is therefore
// a single slice. Latency is STAGES cycles. Each stage has a valid bit, and a
// stage advances when it is empty or when the stage after it advances. Bubbles
// therefore collapse, and the pipeline holds up to STAGES beats.
//
// Parameters
//   WIDTH   operand/result width (default 32)
//   STAGES  pipeline depth = latency (default 4); WIDTH/STAGES must be a multiple of 4
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can take an operand beat this cycle
//   a, b       operands
//   cin        carry-in (add mode only)
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   out_valid  result beat valid
//   out_ready  downstream accepts the result beat
//   sum        result modulo 2^WIDTH
//   cout       carry-out; in sub mode 1 means no borrow (a >= b unsigned)
//   ovf        signed overflow, present only when CLA_OVF_FLAG_EN is defined
//
// Build option
//   CLA_OVF_FLAG_EN  adds the ovf output, pipelined with sum.

module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int S   = WIDTH / STAGES;
  localparam int NG  = S / 4;
  // Operand registers are only needed by stages that still feed a later slice.
  localparam int OPN = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0) || (S == 0) || ((S % 4) != 0)) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH/STAGES must be a positive multiple of 4");
  end

  // 4-bit carry-look-ahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       co;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {co, p ^ c};
  endfunction

  // One slice: NG look-ahead groups, carry rippling group to group.
  function automatic logic [S:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                           input logic ci);
    logic [S-1:0] s;
    logic         c;
    logic [4:0]   grp;
    s = '0;
    c = ci;
    for (int j = 0; j < NG; j++) begin
      grp          = cla4(x[j*4 +: 4], y[j*4 +: 4], c);
      s[j*4 +: 4]  = grp[3:0];
      c            = grp[4];
    end
    return {c, s};
  endfunction

  // Stage state
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q,   c_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  opa_q [OPN];
  logic [WIDTH-1:0]  opa_d [OPN];
  logic [WIDTH-1:0]  opb_q [OPN];   // b_eff: already inverted in sub mode
  logic [WIDTH-1:0]  opb_d [OPN];
`ifdef CLA_OVF_FLAG_EN
  logic              ovf_q, ovf_d;
`endif

  // adv[k]: stage k loads this cycle. adv[STAGES] is the downstream accept.
  logic [STAGES:0] adv;

  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !vld_q[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    logic             src_vld;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_c;
    logic [S:0]       r;

    // NOTE: every signal written here gets a default first; each stage then
    // holds its current contents unless it advances, and no latch can be inferred.
    vld_d = vld_q;
    c_d   = c_q;
    for (int k = 0; k < STAGES; k++) sum_d[k] = sum_q[k];
    for (int k = 0; k < OPN; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
    end
`ifdef CLA_OVF_FLAG_EN
    ovf_d = ovf_q;
`endif
    src_vld = 1'b0;
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    src_c   = 1'b0;
    r       = '0;

    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Subtraction is a + ~b + 1; the inversion and forced carry happen at the entry.
        src_vld = in_valid;
        src_a   = a;
        src_b   = sub ? ~b : b;
        src_sum = '0;
        src_c   = sub ? 1'b1 : cin;
      end else begin
        src_vld = vld_q[k-1];
        src_a   = opa_q[k-1];
        src_b   = opb_q[k-1];
        src_sum = sum_q[k-1];
        src_c   = c_q[k-1];
      end

      r = slice_add(src_a[k*S +: S], src_b[k*S +: S], src_c);

      if (adv[k]) begin
        vld_d[k] = src_vld;
        // Payload only moves with a real beat; bubbles leave stale data behind.
        if (src_vld) begin
          sum_d[k]            = src_sum;
          sum_d[k][k*S +: S]  = r[S-1:0];
          c_d[k]              = r[S];
          if (k < OPN) begin
            opa_d[k] = src_a;
            opb_d[k] = src_b;
          end
`ifdef CLA_OVF_FLAG_EN
          // The last slice holds the MSB, so the sign bits are still in hand here.
          if (k == STAGES - 1) begin
            ovf_d = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (r[S-1] != src_a[WIDTH-1]);
          end
`endif
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages sample
  // the pre-edge values of their neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the stage data is cleared along with the valid bits. sum/cout must
      // read 0 after reset, and on a synchronous reset the clear is only a data-path AND.
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) sum_q[k] <= '0;
      for (int k = 0; k < OPN; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
`ifdef CLA_OVF_FLAG_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      vld_q <= vld_d;
      c_q   <= c_d;
      for (int k = 0; k < STAGES; k++) sum_q[k] <= sum_d[k];
      for (int k = 0; k < OPN; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
`ifdef CLA_OVF_FLAG_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef CLA_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule
